// File: rtl/ahb_mtx_rr_arb.sv
// Round-robin output-stage arbiter for one shared slave port of the AHB matrix.
// Latency: one HCLK edge from request to addr_in_port; handover on the burst-ending edge.
// Backpressure: HREADYM low freezes the tracker and all registered outputs.
//
// Ports:
//   HCLK, HRESET       clock, asynchronous active-high reset
//   req_port           per-input-stage request (bit i = port i)
//   HREADYM, HSELM, HTRANSM, HBURSTM, HMASTLOCKM   observed output-port transfer
//   addr_in_port       input stage owning the address phase
//   no_port            no stage selected, output port drives IDLE
//   arb_hold           registered hold condition (status/debug)
module ahb_mtx_rr_arb #(
  parameter int NUM_PORTS = 4,
  parameter int PORT_W    = 2,
  parameter int INCR_MAX  = 8
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  input  logic [NUM_PORTS-1:0] req_port,
  input  logic                 HREADYM,
  input  logic                 HSELM,
  input  logic [1:0]           HTRANSM,
  input  logic [2:0]           HBURSTM,
  input  logic                 HMASTLOCKM,
  output logic [PORT_W-1:0]    addr_in_port,
  output logic                 no_port,
  output logic                 arb_hold
);

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_BUSY   = 2'b01;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;
  localparam logic [2:0] BR_INCR   = 3'b001;

  // Wide enough to hold INCR_MAX itself, and at least the value 1.
  localparam int IW = $clog2(INCR_MAX + 2);

  logic [3:0]        burst_cnt, burst_cnt_nxt;
  logic              burst_hold, burst_hold_nxt;
  logic [IW-1:0]     incr_cnt, incr_cnt_nxt;
  logic [PORT_W-1:0] rr_last, rr_last_nxt;
  logic [PORT_W-1:0] addr_nxt, rr_idx;
  logic              no_port_nxt, rr_hit;
  logic              incr_hold, hold;

  // Burst tracker next state. incr_cnt is nonzero only inside an INCR burst,
  // so it doubles as the "active INCR" flag.
  always_comb begin
    burst_cnt_nxt  = burst_cnt;
    burst_hold_nxt = burst_hold;
    incr_cnt_nxt   = incr_cnt;
    if (HREADYM) begin
      if (!HSELM) begin
        burst_cnt_nxt  = '0;
        burst_hold_nxt = 1'b0;
        incr_cnt_nxt   = '0;
      end else begin
        case (HTRANSM)
          TR_NONSEQ: begin
            case (HBURSTM)
              3'd6, 3'd7: begin burst_cnt_nxt = 4'd15; burst_hold_nxt = 1'b1; end
              3'd4, 3'd5: begin burst_cnt_nxt = 4'd7;  burst_hold_nxt = 1'b1; end
              3'd2, 3'd3: begin burst_cnt_nxt = 4'd3;  burst_hold_nxt = 1'b1; end
              default:    begin burst_cnt_nxt = 4'd0;  burst_hold_nxt = 1'b0; end
            endcase
            incr_cnt_nxt = (HBURSTM == BR_INCR) ? IW'(1) : '0;
          end
          TR_SEQ: begin
            if (burst_cnt != 4'd0) burst_cnt_nxt = burst_cnt - 4'd1;
            if (burst_cnt == 4'd1) burst_hold_nxt = 1'b0;
            // With INCR_MAX=0 the counter parks at 1, keeping the INCR held.
            if (incr_cnt != '0 && INCR_MAX != 0 && incr_cnt != IW'(INCR_MAX))
              incr_cnt_nxt = incr_cnt + IW'(1);
          end
          TR_BUSY: ;
          default: begin
            burst_cnt_nxt  = '0;
            burst_hold_nxt = 1'b0;
            incr_cnt_nxt   = '0;
          end
        endcase
      end
    end
  end

  // The counter saturates at INCR_MAX, so "!= INCR_MAX" is the "< INCR_MAX" test.
  assign incr_hold = HSELM && (incr_cnt_nxt != '0) && (incr_cnt_nxt != IW'(INCR_MAX));
  assign hold      = HMASTLOCKM | burst_hold_nxt | incr_hold;

  // Circular search starting one past the last granted port.
  always_comb begin
    rr_hit = 1'b0;
    rr_idx = '0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      if (!rr_hit && req_port[(int'(rr_last) + i) % NUM_PORTS]) begin
        rr_hit = 1'b1;
        rr_idx = PORT_W'((int'(rr_last) + i) % NUM_PORTS);
      end
    end
  end

  always_comb begin
    addr_nxt    = addr_in_port;
    rr_last_nxt = rr_last;
    no_port_nxt = 1'b0;
    if (!hold) begin
      if (rr_hit) begin
        addr_nxt    = rr_idx;
        rr_last_nxt = rr_idx;
      end else if (!HSELM) begin
        no_port_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      burst_cnt    <= '0;
      burst_hold   <= 1'b0;
      incr_cnt     <= '0;
      rr_last      <= PORT_W'(NUM_PORTS - 1);
      addr_in_port <= '0;
      no_port      <= 1'b1;
      arb_hold     <= 1'b0;
    end else begin
      burst_cnt  <= burst_cnt_nxt;
      burst_hold <= burst_hold_nxt;
      incr_cnt   <= incr_cnt_nxt;
      if (HREADYM) begin
        addr_in_port <= addr_nxt;
        no_port      <= no_port_nxt;
        rr_last      <= rr_last_nxt;
        arb_hold     <= hold;
      end
    end
  end

endmodule
